// File: rtl/escalonador_pkg.sv
// Shared definitions for the projectile shot scheduler: FSM encoding,
// spawn offsets, screen limit and edge-detector reset value.
package escalonador_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ARBITRA = 2'd1,
    EMITE   = 2'd2,
    LIBERA  = 2'd3
  } estado_t;

  localparam logic [9:0] OFFSET_ALIADO  = 10'd10;
  localparam logic [9:0] OFFSET_INIMIGO = 10'd20;
  localparam logic [9:0] Y_LIMITE       = 10'd479;

  // A fire button already held when reset releases must not count as an edge.
  localparam logic EDGE_PREV_RST = 1'b1;

  function automatic logic [9:0] y_tiro_aliado(input logic [9:0] y);
    return (y < OFFSET_ALIADO) ? 10'd0 : (y - OFFSET_ALIADO);
  endfunction

  function automatic logic [9:0] y_tiro_inimigo(input logic [9:0] y);
    logic [10:0] soma;
    soma = {1'b0, y} + {1'b0, OFFSET_INIMIGO};
    return (soma > {1'b0, Y_LIMITE}) ? Y_LIMITE : soma[9:0];
  endfunction

endpackage

// File: rtl/escalonador_tiros_divisor_tick.sv
// Game-tick generator: one-cycle pulse every DIV_TICK clocks, frozen by pausa
// and cleared synchronously by clr.
module divisor_tick #(
  parameter int DIV_TICK = 200000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic pausa,
  output logic tick
);

  localparam int CW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (!pausa) begin
      if (cnt_q == CW'(DIV_TICK - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/escalonador_tiros.sv
// Shot scheduler: captures ally/enemy fire edges, applies per-shooter cooldown,
// arbitrates (ally first, enemies round-robin) and hands shots to free projectile slots.
module escalonador_tiros
  import escalonador_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_INIMIGOS    = 4,
  parameter int DIV_TICK        = 200000,
  parameter int RECARGA_ALIADO  = 20,
  parameter int RECARGA_INIMIGO = 60
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      pausa,
  input  logic                      reiniciarJogo,
  input  logic                      disparo_aliado,
  input  logic [9:0]                x_aliado,
  input  logic [9:0]                y_aliado,
  input  logic [NUM_INIMIGOS-1:0]   disparo_inimigo,
  input  logic [10*NUM_INIMIGOS-1:0] x_inimigos,
  input  logic [10*NUM_INIMIGOS-1:0] y_inimigos,
  input  logic [NUM_SLOTS-1:0]      slot_livre,
  output logic [NUM_SLOTS-1:0]      iniciar_movimento,
  output logic [10*NUM_SLOTS-1:0]   xi,
  output logic [10*NUM_SLOTS-1:0]   yi,
  output logic [NUM_SLOTS-1:0]      ehAliada,
  output logic                      tiro_negado,
  output logic                      erro_slot,
  output logic [2:0]                ocupados
);

  localparam int NS     = NUM_SLOTS;
  localparam int NI     = NUM_INIMIGOS;
  localparam int SW     = (NS > 1) ? $clog2(NS) : 1;
  localparam int IW     = (NI > 1) ? $clog2(NI) : 1;
  localparam int CD_MAX = (RECARGA_ALIADO > RECARGA_INIMIGO) ? RECARGA_ALIADO : RECARGA_INIMIGO;
  localparam int CDW    = $clog2(CD_MAX + 1);
  localparam int TO_LIM = 2 * DIV_TICK + 2;
  localparam int TW     = $clog2(TO_LIM);

  logic tick;

  divisor_tick #(
    .DIV_TICK(DIV_TICK)
  ) u_divisor_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clr     (reiniciarJogo),
    .pausa   (pausa),
    .tick    (tick)
  );

  estado_t                 state_q, state_d;
  logic                    prev_a_q, prev_a_d;
  logic                    pend_a_q, pend_a_d;
  logic [NI-1:0]           prev_e_q, prev_e_d;
  logic [NI-1:0]           pend_e_q, pend_e_d;
  logic [CDW-1:0]          cd_a_q, cd_a_d;
  logic [NI-1:0][CDW-1:0]  cd_e_q, cd_e_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           win_idx_q, win_idx_d;
  logic                    win_a_q, win_a_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [TW-1:0]           to_q, to_d;
  logic [10*NS-1:0]        xi_q, xi_d;
  logic [10*NS-1:0]        yi_q, yi_d;
  logic [NS-1:0]           eh_q, eh_d;
  logic                    negado_q, negado_d;
  logic                    erro_q, erro_d;
  logic [2:0]              ocup_q, ocup_d;

  // Round-robin enemy pick and lowest free slot; lower loop index overwrites last.
  logic          rr_found;
  logic [IW-1:0] rr_idx;
  logic          livre_found;
  logic [SW-1:0] livre_idx;
  logic [2:0]    busy_cnt;
  int            idx;

  always_comb begin
    rr_found    = 1'b0;
    rr_idx      = '0;
    livre_found = 1'b0;
    livre_idx   = '0;
    busy_cnt    = '0;
    idx         = 0;
    for (int k = NI - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NI) idx = idx - NI;
      if (pend_e_q[idx]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(idx);
      end
    end
    for (int i = NS - 1; i >= 0; i--) begin
      if (slot_livre[i]) begin
        livre_found = 1'b1;
        livre_idx   = SW'(i);
      end
    end
    for (int i = 0; i < NS; i++) begin
      busy_cnt = busy_cnt + {2'b00, ~slot_livre[i]};
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_a_d  = prev_a_q;
    pend_a_d  = pend_a_q;
    prev_e_d  = prev_e_q;
    pend_e_d  = pend_e_q;
    cd_a_d    = cd_a_q;
    cd_e_d    = cd_e_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    win_a_d   = win_a_q;
    slot_d    = slot_q;
    to_d      = to_q;
    xi_d      = xi_q;
    yi_d      = yi_q;
    eh_d      = eh_q;
    negado_d  = negado_q;
    erro_d    = erro_q;
    ocup_d    = ocup_q;

    if (!pausa) begin
      prev_a_d = disparo_aliado;
      prev_e_d = disparo_inimigo;
      negado_d = 1'b0;
      ocup_d   = busy_cnt;

      if (disparo_aliado && !prev_a_q) begin
        if (cd_a_q != '0) negado_d = 1'b1;
        else              pend_a_d = 1'b1;
      end
      for (int k = 0; k < NI; k++) begin
        if (disparo_inimigo[k] && !prev_e_q[k]) begin
          if (cd_e_q[k] != '0) negado_d    = 1'b1;
          else                 pend_e_d[k] = 1'b1;
        end
      end

      if (tick) begin
        if (cd_a_q != '0) cd_a_d = cd_a_q - CDW'(1);
        for (int k = 0; k < NI; k++) begin
          if (cd_e_q[k] != '0) cd_e_d[k] = cd_e_q[k] - CDW'(1);
        end
      end

      unique case (state_q)
        OCIOSO: begin
          if ((pend_a_q || (|pend_e_q)) && (|slot_livre)) state_d = ARBITRA;
        end
        ARBITRA: begin
          if ((pend_a_q || rr_found) && livre_found) begin
            win_a_d   = pend_a_q;
            win_idx_d = rr_idx;
            slot_d    = livre_idx;
            to_d      = '0;
            state_d   = EMITE;
            if (pend_a_q) begin
              xi_d[livre_idx*10 +: 10] = x_aliado;
              yi_d[livre_idx*10 +: 10] = y_tiro_aliado(y_aliado);
              eh_d[livre_idx]          = 1'b1;
            end else begin
              xi_d[livre_idx*10 +: 10] = x_inimigos[rr_idx*10 +: 10];
              yi_d[livre_idx*10 +: 10] = y_tiro_inimigo(y_inimigos[rr_idx*10 +: 10]);
              eh_d[livre_idx]          = 1'b0;
            end
          end else begin
            state_d = OCIOSO;
          end
        end
        EMITE: begin
          if (!slot_livre[slot_q]) begin
            state_d = LIBERA;
          end else if (to_q == TW'(TO_LIM - 1)) begin
            // Slot never acknowledged: abandon this shot rather than stall everyone.
            erro_d  = 1'b1;
            state_d = OCIOSO;
            if (win_a_q) pend_a_d            = 1'b0;
            else         pend_e_d[win_idx_q] = 1'b0;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        LIBERA: begin
          state_d = OCIOSO;
          if (win_a_q) begin
            pend_a_d = 1'b0;
            cd_a_d   = CDW'(RECARGA_ALIADO);
          end else begin
            pend_e_d[win_idx_q] = 1'b0;
            cd_e_d[win_idx_q]   = CDW'(RECARGA_INIMIGO);
            ptr_d = (win_idx_q == IW'(NI - 1)) ? '0 : (win_idx_q + IW'(1));
          end
        end
        default: state_d = OCIOSO;
      endcase
    end

    // New game wipes everything but the sticky slot-error flag.
    if (reiniciarJogo) begin
      state_d   = OCIOSO;
      prev_a_d  = EDGE_PREV_RST;
      pend_a_d  = 1'b0;
      prev_e_d  = {NI{EDGE_PREV_RST}};
      pend_e_d  = '0;
      cd_a_d    = '0;
      cd_e_d    = '0;
      ptr_d     = '0;
      win_idx_d = '0;
      win_a_d   = 1'b0;
      slot_d    = '0;
      to_d      = '0;
      xi_d      = '0;
      yi_d      = '0;
      eh_d      = '0;
      negado_d  = 1'b0;
      erro_d    = erro_q;
      ocup_d    = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      prev_a_q  <= EDGE_PREV_RST;
      pend_a_q  <= 1'b0;
      prev_e_q  <= {NI{EDGE_PREV_RST}};
      pend_e_q  <= '0;
      cd_a_q    <= '0;
      cd_e_q    <= '0;
      ptr_q     <= '0;
      win_idx_q <= '0;
      win_a_q   <= 1'b0;
      slot_q    <= '0;
      to_q      <= '0;
      xi_q      <= '0;
      yi_q      <= '0;
      eh_q      <= '0;
      negado_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocup_q    <= '0;
    end else begin
      state_q   <= state_d;
      prev_a_q  <= prev_a_d;
      pend_a_q  <= pend_a_d;
      prev_e_q  <= prev_e_d;
      pend_e_q  <= pend_e_d;
      cd_a_q    <= cd_a_d;
      cd_e_q    <= cd_e_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      win_a_q   <= win_a_d;
      slot_q    <= slot_d;
      to_q      <= to_d;
      xi_q      <= xi_d;
      yi_q      <= yi_d;
      eh_q      <= eh_d;
      negado_q  <= negado_d;
      erro_q    <= erro_d;
      ocup_q    <= ocup_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_iniciar
      assign iniciar_movimento[gi] = (state_q == EMITE) && (slot_q == SW'(gi));
    end
  endgenerate

  assign xi          = xi_q;
  assign yi          = yi_q;
  assign ehAliada    = eh_q;
  assign tiro_negado = negado_q;
  assign erro_slot   = erro_q;
  assign ocupados    = ocup_q;

endmodule

// File: tb/tb_escalonador_tiros.sv
// Bench for escalonador_tiros: table of single shots plus hand-written sequences
// for simultaneous requests, cooldown denial, full slots, stuck slot and new game.
module tb_escalonador_tiros;

  localparam int NS  = 4;
  localparam int NI  = 4;
  localparam int DIV = 4;

  logic             CLOCK_50 = 1'b0;
  logic             reset, pausa, reiniciarJogo, disparo_aliado;
  logic [9:0]       x_aliado, y_aliado;
  logic [NI-1:0]    disparo_inimigo;
  logic [10*NI-1:0] x_inimigos, y_inimigos;
  logic [NS-1:0]    slot_livre, iniciar_movimento, ehAliada;
  logic [10*NS-1:0] xi, yi;
  logic             tiro_negado, erro_slot;
  logic [2:0]       ocupados;

  always #10 CLOCK_50 = ~CLOCK_50;

  escalonador_tiros #(
    .NUM_SLOTS(NS), .NUM_INIMIGOS(NI), .DIV_TICK(DIV),
    .RECARGA_ALIADO(20), .RECARGA_INIMIGO(60)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .disparo_aliado(disparo_aliado), .x_aliado(x_aliado), .y_aliado(y_aliado),
    .disparo_inimigo(disparo_inimigo), .x_inimigos(x_inimigos), .y_inimigos(y_inimigos),
    .slot_livre(slot_livre), .iniciar_movimento(iniciar_movimento), .xi(xi), .yi(yi),
    .ehAliada(ehAliada), .tiro_negado(tiro_negado), .erro_slot(erro_slot), .ocupados(ocupados)
  );

  typedef struct {
    logic [1:0] slot;
    logic [9:0] x;
    logic [9:0] y;
    logic       eh;
  } exp_t;

  typedef struct {
    bit         ally;
    int         eidx;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] livre;
    logic [1:0] e_slot;
    logic [9:0] e_yi;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fire(input bit ally, input logic [NI-1:0] emask);
    disparo_aliado  = ally;
    disparo_inimigo = emask;
    @(negedge CLOCK_50);
    disparo_aliado  = 1'b0;
    disparo_inimigo = '0;
  endtask

  task automatic set_enemy(input int k, input logic [9:0] x, input logic [9:0] y);
    x_inimigos[k*10 +: 10] = x;
    y_inimigos[k*10 +: 10] = y;
  endtask

  task automatic wait_grant(input string name);
    exp_t          e;
    bit            seen;
    int            s;
    logic [NS-1:0] oh;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (iniciar_movimento != '0) seen = 1'b1;
      else @(negedge CLOCK_50);
    end
    chk({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({name, "_grant_seen"}, 32'(seen), 32'd1);
      if (seen) begin
        s     = int'(e.slot);
        oh    = '0;
        oh[s] = 1'b1;
        chk({name, "_iniciar"}, 32'(iniciar_movimento), 32'(oh));
        chk({name, "_xi"}, 32'(xi[s*10 +: 10]), 32'(e.x));
        chk({name, "_yi"}, 32'(yi[s*10 +: 10]), 32'(e.y));
        chk({name, "_eh"}, 32'(ehAliada[s]), 32'(e.eh));
      end
    end
  endtask

  task automatic ack(input int s);
    slot_livre[s] = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic quiet(input string name, input int n);
    int g;
    int d;
    g = 0;
    d = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      if (iniciar_movimento != '0) g++;
      if (tiro_negado) d++;
    end
    chk({name, "_no_grant"}, 32'(g), 32'd0);
    chk({name, "_no_negado"}, 32'(d), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [NI-1:0] em;
    int            hi;

    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0;
    disparo_aliado = 1'b0; disparo_inimigo = '0;
    x_aliado = '0; y_aliado = '0; x_inimigos = '0; y_inimigos = '0;
    slot_livre = '1;

    vt[0] = '{1'b1, 0, 10'd100, 10'd200, 4'b1111, 2'd0, 10'd190};
    vt[1] = '{1'b1, 0, 10'd7,   10'd5,   4'b1111, 2'd0, 10'd0};
    vt[2] = '{1'b1, 0, 10'd639, 10'd10,  4'b1111, 2'd0, 10'd0};
    vt[3] = '{1'b0, 0, 10'd50,  10'd100, 4'b1111, 2'd0, 10'd120};
    vt[4] = '{1'b0, 3, 10'd600, 10'd459, 4'b1111, 2'd0, 10'd479};
    vt[5] = '{1'b0, 1, 10'd320, 10'd470, 4'b1111, 2'd0, 10'd479};
    vt[6] = '{1'b0, 2, 10'd1,   10'd0,   4'b1100, 2'd2, 10'd20};
    vt[7] = '{1'b0, 0, 10'd5,   10'd11,  4'b1110, 2'd1, 10'd31};

    repeat (3) @(negedge CLOCK_50);
    chk("rst_iniciar", 32'(iniciar_movimento), 32'd0);
    chk("rst_negado", 32'(tiro_negado), 32'd0);
    chk("rst_erro", 32'(erro_slot), 32'd0);
    chk("rst_ocupados", 32'(ocupados), 32'd0);
    chk("rst_xi", 32'(xi[31:0]), 32'd0);
    chk("rst_yi", 32'(yi[31:0]), 32'd0);
    chk("rst_eh", 32'(ehAliada), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    for (int i = 0; i < 8; i++) begin
      slot_livre = vt[i].livre;
      em = '0;
      if (vt[i].ally) begin
        x_aliado = vt[i].x;
        y_aliado = vt[i].y;
      end else begin
        set_enemy(vt[i].eidx, vt[i].x, vt[i].y);
        em[vt[i].eidx] = 1'b1;
      end
      sb.push_back('{vt[i].e_slot, vt[i].x, vt[i].e_yi, vt[i].ally});
      fire(vt[i].ally, em);
      wait_grant($sformatf("vec%0d", i));
      ack(int'(vt[i].e_slot));
      @(negedge CLOCK_50);
      chk($sformatf("vec%0d_ocupados", i), 32'(ocupados), 32'($countones(~slot_livre)));
      slot_livre = '1;
      repeat (250) @(negedge CLOCK_50);
    end

    // Ally and enemy 2 in the same cycle.
    x_aliado = 10'd321; y_aliado = 10'd300;
    set_enemy(2, 10'd77, 10'd40);
    sb.push_back('{2'd0, 10'd321, 10'd290, 1'b1});
    sb.push_back('{2'd1, 10'd77, 10'd60, 1'b0});
    fire(1'b1, 4'b0100);
    wait_grant("simul_ally");
    ack(0);
    wait_grant("simul_enemy2");
    ack(1);
    slot_livre = '1;

    // Ally re-fire inside its cooldown.
    repeat (20) @(negedge CLOCK_50);
    fire(1'b1, '0);
    chk("refire_negado_pulse", 32'(tiro_negado), 32'd1);
    @(negedge CLOCK_50);
    chk("refire_negado_one_cycle", 32'(tiro_negado), 32'd0);
    quiet("refire", 15);

    // No free slot, then slot 3 frees up.
    repeat (100) @(negedge CLOCK_50);
    slot_livre = '0;
    set_enemy(1, 10'd222, 10'd470);
    fire(1'b0, 4'b0010);
    quiet("full", 12);
    chk("full_ocupados", 32'(ocupados), 32'd4);
    sb.push_back('{2'd3, 10'd222, 10'd479, 1'b0});
    slot_livre = 4'b1000;
    wait_grant("slot3_clamp");
    ack(3);
    slot_livre = '1;

    // Slot 0 never leaves idle: timeout.
    repeat (100) @(negedge CLOCK_50);
    chk("stuck_erro_before", 32'(erro_slot), 32'd0);
    x_aliado = 10'd10; y_aliado = 10'd50;
    sb.push_back('{2'd0, 10'd10, 10'd40, 1'b1});
    fire(1'b1, '0);
    wait_grant("stuck");
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      if (!iniciar_movimento[0]) break;
      hi++;
      @(negedge CLOCK_50);
    end
    chk("stuck_hold_cycles", 32'(hi), 32'(2 * DIV + 2));
    chk("stuck_erro_set", 32'(erro_slot), 32'd1);
    chk("stuck_iniciar_dropped", 32'(iniciar_movimento), 32'd0);
    quiet("stuck_cleared", 12);

    // New game in the middle of an emission.
    set_enemy(0, 10'd9, 10'd9);
    sb.push_back('{2'd0, 10'd9, 10'd29, 1'b0});
    fire(1'b0, 4'b0001);
    wait_grant("reinit");
    repeat (3) @(negedge CLOCK_50);
    reiniciarJogo = 1'b1;
    @(negedge CLOCK_50);
    reiniciarJogo = 1'b0;
    chk("reinit_iniciar", 32'(iniciar_movimento), 32'd0);
    chk("reinit_erro_kept", 32'(erro_slot), 32'd1);
    chk("reinit_xi_cleared", 32'(xi[9:0]), 32'd0);
    quiet("reinit_pending", 12);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
